cf_ide_target: RTL

CompactFlash True-IDE device-side responder: the card end of the bus our CF host controller drives. It decodes `cs_n`/`addr`/`iord_n`/`iowr_n`, implements the ATA task file and a 512-byte sector buffer, and runs READ SECTORS / WRITE SECTORS against a backing-store port. It is used as a card emulator in system simulation and on boards without a physical CF socket.

---
 rtl/cf_ide_pkg.sv | 60 ++++++
 rtl/cf_sector_buf.sv | 26 ++
 rtl/cf_ide_target.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cf_ide_pkg.sv
// Shared definitions for the CompactFlash True-IDE card responder:
// register map, status bits, opcodes and the protocol FSM states.
package cf_ide_pkg;

    localparam logic [1:0] CS_CMD  = 2'b10;
    localparam logic [1:0] CS_CTRL = 2'b01;

    localparam logic [2:0] REG_DATA       = 3'd0;
    localparam logic [2:0] REG_ERROR      = 3'd1;
    localparam logic [2:0] REG_FEATURES   = 3'd1;
    localparam logic [2:0] REG_COUNT      = 3'd2;
    localparam logic [2:0] REG_LBA_LO     = 3'd3;
    localparam logic [2:0] REG_LBA_MID    = 3'd4;
    localparam logic [2:0] REG_LBA_HI     = 3'd5;
    localparam logic [2:0] REG_DEVICE     = 3'd6;
    localparam logic [2:0] REG_STATUS     = 3'd7;
    localparam logic [2:0] REG_COMMAND    = 3'd7;
    localparam logic [2:0] REG_ALT_STATUS = 3'd6;
    localparam logic [2:0] REG_DEV_CTRL   = 3'd6;

    localparam int ST_BSY  = 7;
    localparam int ST_DRDY = 6;
    localparam int ST_DSC  = 4;
    localparam int ST_DRQ  = 3;
    localparam int ST_ERR  = 0;

    localparam logic [7:0] CMD_READ_SECTORS  = 8'h20;
    localparam logic [7:0] CMD_WRITE_SECTORS = 8'h30;
    localparam logic [7:0] ERR_ABRT          = 8'h04;
    localparam logic [7:0] ERROR_RESET_VAL   = 8'h01;

    localparam int BUF_AW    = 8;
    localparam int BUF_WORDS = 256;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_XFER,
        WR_XFER,
        WR_COMMIT,
        SRST_HOLD
    } cf_state_e;

    // Soft reset reports BSY alone; otherwise BSY/DRQ follow the protocol state.
    function automatic logic [7:0] make_status(input cf_state_e st, input logic err);
        logic [7:0] s;
        s = 8'h00;
        if (st == SRST_HOLD) begin
            s[ST_BSY] = 1'b1;
        end else begin
            s[ST_DRDY] = 1'b1;
            s[ST_DSC]  = 1'b1;
            s[ST_BSY]  = (st == RD_FETCH) || (st == WR_COMMIT);
            s[ST_DRQ]  = (st == RD_XFER) || (st == WR_XFER);
            s[ST_ERR]  = err;
        end
        return s;
    endfunction

endpackage

// File: rtl/cf_sector_buf.sv
// 256x16 true dual-port sector buffer; port A faces the host, port B the
// backing store. Both ports have one cycle of read latency.
module cf_sector_buf
    import cf_ide_pkg::*;
(
    input  logic              clk,
    input  logic [BUF_AW-1:0] a_addr,
    input  logic [15:0]       a_wdata,
    input  logic              a_we,
    output logic [15:0]       a_rdata,
    input  logic [BUF_AW-1:0] b_addr,
    input  logic [15:0]       b_wdata,
    input  logic              b_we,
    output logic [15:0]       b_rdata
);

    logic [15:0] mem [0:BUF_WORDS-1];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/cf_ide_target.sv
// CompactFlash True-IDE device-side responder: task file, sector buffer and
// READ/WRITE SECTORS sequencing against a backing-store port.
module cf_ide_target
    import cf_ide_pkg::*;
#(
    parameter int BK_LBA_W = 28
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reset_n_cf,
    input  logic [1:0]          cs_n,
    input  logic [2:0]          addr,
    input  logic                iord_n,
    input  logic                iowr_n,
    input  logic [15:0]         data_in,
    output logic [15:0]         data_out,
    output logic                data_oe,
    output logic                intrq,
    output logic                iordy,
    output logic                bk_req,
    output logic                bk_write,
    output logic [BK_LBA_W-1:0] bk_lba,
    input  logic                bk_ack,
    input  logic [7:0]          bk_addr,
    input  logic [15:0]         bk_wdata,
    input  logic                bk_we,
    output logic [15:0]         bk_rdata
);

    logic [2:0]  iord_sync_q, iowr_sync_q;
    logic [1:0]  cfrst_sync_q;
    logic [1:0]  cs_s1_q, cs_s2_q, rd_cs_q, wr_cs_q;
    logic [2:0]  addr_s1_q, addr_s2_q, rd_addr_q, wr_addr_q;
    logic [15:0] din_s1_q, din_s2_q, wr_data_q;

    cf_state_e   state_q, state_d;
    logic [7:0]  count_q, count_d, lba_lo_q, lba_lo_d, lba_mid_q, lba_mid_d;
    logic [7:0]  lba_hi_q, lba_hi_d, device_q, device_d, error_q, error_d;
    logic [7:0]  ptr_q, ptr_d, count_dec;
    logic        err_q, err_d, nien_q, nien_d, srst_q, srst_d;
    logic        irq_pend_q, irq_pend_d, intrq_q, intrq_d;
    logic        bk_req_q, bk_req_d, bk_write_q, bk_write_d;
    logic [15:0] data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;

    logic [27:0] lba_cur, lba_next;
    logic [7:0]  status;
    logic        busy, srst_active, rd_edge, wr_edge, tf_wr, cmd_wr;
    logic        data_rd, data_wr, rd_sel_cmd, rd_sel_ctrl, a_we;
    logic [15:0] buf_rdata;

    // Host strobes are asynchronous; address/data ride a matching 2-stage delay
    // and are latched while the synchronised strobe is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iord_sync_q  <= '1;
            iowr_sync_q  <= '1;
            cfrst_sync_q <= '1;
            cs_s1_q      <= '1;
            cs_s2_q      <= '1;
            addr_s1_q    <= '0;
            addr_s2_q    <= '0;
            din_s1_q     <= '0;
            din_s2_q     <= '0;
            rd_cs_q      <= '1;
            rd_addr_q    <= '0;
            wr_cs_q      <= '1;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            iord_sync_q  <= {iord_sync_q[1:0], iord_n};
            iowr_sync_q  <= {iowr_sync_q[1:0], iowr_n};
            cfrst_sync_q <= {cfrst_sync_q[0], reset_n_cf};
            cs_s1_q      <= cs_n;
            cs_s2_q      <= cs_s1_q;
            addr_s1_q    <= addr;
            addr_s2_q    <= addr_s1_q;
            din_s1_q     <= data_in;
            din_s2_q     <= din_s1_q;
            if (!iord_sync_q[1]) begin
                rd_cs_q   <= cs_s2_q;
                rd_addr_q <= addr_s2_q;
            end
            if (!iowr_sync_q[1]) begin
                wr_cs_q   <= cs_s2_q;
                wr_addr_q <= addr_s2_q;
                wr_data_q <= din_s2_q;
            end
        end
    end

    assign rd_edge     = iord_sync_q[1] & ~iord_sync_q[2];
    assign wr_edge     = iowr_sync_q[1] & ~iowr_sync_q[2];
    assign tf_wr       = wr_edge && (wr_cs_q == CS_CMD);
    assign cmd_wr      = tf_wr && !busy && (wr_addr_q == REG_COMMAND);
    assign data_rd     = rd_edge && (rd_cs_q == CS_CMD) && (rd_addr_q == REG_DATA);
    assign data_wr     = tf_wr && (wr_addr_q == REG_DATA);
    assign status      = make_status(state_q, err_q);
    assign busy        = status[ST_BSY];
    assign srst_active = srst_q | ~cfrst_sync_q[1];
    assign lba_cur     = {device_q[3:0], lba_hi_q, lba_mid_q, lba_lo_q};

    cf_sector_buf u_buf (
        .clk     (clk),
        .a_addr  (ptr_q),
        .a_wdata (wr_data_q),
        .a_we    (a_we),
        .a_rdata (buf_rdata),
        .b_addr  (bk_addr),
        .b_wdata (bk_wdata),
        .b_we    (bk_we),
        .b_rdata (bk_rdata)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        lba_lo_d   = lba_lo_q;
        lba_mid_d  = lba_mid_q;
        lba_hi_d   = lba_hi_q;
        device_d   = device_q;
        error_d    = error_q;
        err_d      = err_q;
        nien_d     = nien_q;
        srst_d     = srst_q;
        irq_pend_d = irq_pend_q;
        bk_req_d   = bk_req_q;
        bk_write_d = bk_write_q;
        ptr_d      = ptr_q;
        a_we       = 1'b0;
        intrq_d    = irq_pend_q & ~nien_q;
        lba_next   = lba_cur + 28'd1;
        count_dec  = count_q - 8'd1;

        if (wr_edge && (wr_cs_q == CS_CTRL) && (wr_addr_q == REG_DEV_CTRL)) begin
            nien_d = wr_data_q[1];
            srst_d = wr_data_q[2];
        end
        if (rd_edge && (rd_cs_q == CS_CMD) && (rd_addr_q == REG_STATUS))
            irq_pend_d = 1'b0;

        if (tf_wr && !busy) begin
            case (wr_addr_q)
                REG_COUNT:   count_d    = wr_data_q[7:0];
                REG_LBA_LO:  lba_lo_d   = wr_data_q[7:0];
                REG_LBA_MID: lba_mid_d  = wr_data_q[7:0];
                REG_LBA_HI:  lba_hi_d   = wr_data_q[7:0];
                REG_DEVICE:  device_d   = wr_data_q[7:0];
                REG_COMMAND: irq_pend_d = 1'b0;
                default: ;
            endcase
        end

        if (srst_active) begin
            state_d    = SRST_HOLD;
            bk_req_d   = 1'b0;
            irq_pend_d = 1'b0;
        end else begin
            case (state_q)
                SRST_HOLD: begin
                    state_d    = IDLE;
                    count_d    = 8'h00;
                    lba_lo_d   = 8'h00;
                    lba_mid_d  = 8'h00;
                    lba_hi_d   = 8'h00;
                    device_d   = 8'h00;
                    error_d    = ERROR_RESET_VAL;
                    err_d      = 1'b0;
                    ptr_d      = 8'h00;
                    bk_write_d = 1'b0;
                end
                IDLE: begin
                    if (cmd_wr) begin
                        ptr_d = 8'h00;
                        err_d = 1'b0;
                        case (wr_data_q[7:0])
                            CMD_READ_SECTORS: begin
                                state_d    = RD_FETCH;
                                bk_req_d   = 1'b1;
                                bk_write_d = 1'b0;
                            end
                            CMD_WRITE_SECTORS: state_d = WR_XFER;
                            default: begin
                                err_d      = 1'b1;
                                error_d    = ERR_ABRT;
                                irq_pend_d = 1'b1;
                            end
                        endcase
                    end
                end
                RD_FETCH: begin
                    if (bk_ack) begin
                        state_d    = RD_XFER;
                        bk_req_d   = 1'b0;
                        irq_pend_d = 1'b1;
                    end
                end
                RD_XFER: begin
                    if (data_rd) begin
                        ptr_d = ptr_q + 8'd1;
                        if (ptr_q == 8'hFF) begin
                            count_d = count_dec;
                            {device_d[3:0], lba_hi_d, lba_mid_d, lba_lo_d} = lba_next;
                            if (count_dec == 8'h00) begin
                                state_d = IDLE;
                            end else begin
                                state_d  = RD_FETCH;
                                bk_req_d = 1'b1;
                            end
                        end
                    end
                end
                WR_XFER: begin
                    if (data_wr) begin
                        a_we  = 1'b1;
                        ptr_d = ptr_q + 8'd1;
                        if (ptr_q == 8'hFF) begin
                            state_d    = WR_COMMIT;
                            bk_req_d   = 1'b1;
                            bk_write_d = 1'b1;
                        end
                    end
                end
                WR_COMMIT: begin
                    if (bk_ack) begin
                        bk_req_d   = 1'b0;
                        irq_pend_d = 1'b1;
                        count_d    = count_dec;
                        {device_d[3:0], lba_hi_d, lba_mid_d, lba_lo_d} = lba_next;
                        state_d    = (count_dec == 8'h00) ? IDLE : WR_XFER;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read data is registered straight from the raw pins so the pad sees it one cycle after they settle.
    always_comb begin
        rd_sel_cmd  = (cs_n == CS_CMD);
        rd_sel_ctrl = (cs_n == CS_CTRL) && (addr == REG_ALT_STATUS);
        data_oe_d   = !iord_n && (rd_sel_cmd || rd_sel_ctrl);
        data_out_d  = 16'h0000;
        if (data_oe_d) begin
            if (rd_sel_ctrl) begin
                data_out_d = {8'h00, status};
            end else begin
                case (addr)
                    REG_DATA:    data_out_d = (state_q == RD_XFER) ? buf_rdata : 16'h0000;
                    REG_ERROR:   data_out_d = {8'h00, error_q};
                    REG_COUNT:   data_out_d = {8'h00, count_q};
                    REG_LBA_LO:  data_out_d = {8'h00, lba_lo_q};
                    REG_LBA_MID: data_out_d = {8'h00, lba_mid_q};
                    REG_LBA_HI:  data_out_d = {8'h00, lba_hi_q};
                    REG_DEVICE:  data_out_d = {8'h00, device_q};
                    default:     data_out_d = {8'h00, status};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= 8'h00;
            lba_lo_q   <= 8'h00;
            lba_mid_q  <= 8'h00;
            lba_hi_q   <= 8'h00;
            device_q   <= 8'h00;
            error_q    <= ERROR_RESET_VAL;
            err_q      <= 1'b0;
            nien_q     <= 1'b0;
            srst_q     <= 1'b0;
            irq_pend_q <= 1'b0;
            intrq_q    <= 1'b0;
            bk_req_q   <= 1'b0;
            bk_write_q <= 1'b0;
            ptr_q      <= 8'h00;
            data_out_q <= 16'h0000;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            lba_lo_q   <= lba_lo_d;
            lba_mid_q  <= lba_mid_d;
            lba_hi_q   <= lba_hi_d;
            device_q   <= device_d;
            error_q    <= error_d;
            err_q      <= err_d;
            nien_q     <= nien_d;
            srst_q     <= srst_d;
            irq_pend_q <= irq_pend_d;
            intrq_q    <= intrq_d;
            bk_req_q   <= bk_req_d;
            bk_write_q <= bk_write_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign intrq    = intrq_q;
    assign iordy    = 1'b1;
    assign bk_req   = bk_req_q;
    assign bk_write = bk_write_q;
    assign bk_lba   = BK_LBA_W'(lba_cur);

endmodule
